ram_access_ctrl: RTL and testbench

Initiator side of the 32x8 single-port synchronous RAM interface (address, clock, data, wren, q).
- Replaces the manual switch-driven access to that RAM.
- Accepts single-word write requests, and read requests of 1 to 32 consecutive words, through a valid/ready handshake.
- Drives the RAM port and returns read data as a tagged response stream for display or test logic.

---
 rtl/ram_access_ctrl_pkg.sv | 21 ++
 rtl/ram_access_ctrl_if.sv | 36 +++
 rtl/ram_access_ctrl_rd_tag_pipe.sv | 37 +++
 rtl/ram_access_ctrl.sv | 143 ++++++++++++++
 tb/tb_ram_access_ctrl.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_access_ctrl_pkg.sv
// Shared types and default widths for the RAM access controller.
package ram_ctrl_pkg;

   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN
   } state_e;

   // Tag travelling alongside each issued read address until its data returns.
   typedef struct packed {
      logic                  valid;
      logic [DEF_ADDR_W-1:0] addr;
      logic                  last;
   } rsp_tag_t;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// Request, response and RAM-port signals of the RAM access controller.
interface ram_access_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [ADDR_W-1:0] req_len;
   logic [DATA_W-1:0] req_wdata;

   logic              rsp_valid;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;

   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_q;

   // Controller view.
   modport slave (
      input  req_valid, req_write, req_addr, req_len, req_wdata, ram_q,
      output req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last,
             ram_address, ram_data, ram_wren
   );

   // Requester / RAM view.
   modport master (
      output req_valid, req_write, req_addr, req_len, req_wdata, ram_q,
      input  req_ready, rsp_valid, rsp_addr, rsp_data, rsp_last,
             ram_address, ram_data, ram_wren
   );
endinterface

// File: rtl/ram_access_ctrl_rd_tag_pipe.sv
// Delays read tags by the RAM read latency so they line up with ram_q.
module rd_tag_pipe
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned RD_LAT = 1
) (
   input  logic     clock,
   input  logic     resetn,
   input  rsp_tag_t tag_i,
   output rsp_tag_t tag_o
);

   rsp_tag_t stage_q [RD_LAT];
   rsp_tag_t stage_d [RD_LAT];

   // Shift one stage per cycle.
   always_comb begin
      stage_d[0] = tag_i;
      for (int i = 1; i < int'(RD_LAT); i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   // Reset drops every in-flight tag so an aborted burst produces no beats.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tag_o = stage_q[RD_LAT-1];

endmodule

// File: rtl/ram_access_ctrl.sv
// Initiator for a single-port synchronous RAM: single-word writes and
// wrapping burst reads of 1..32 words, returned as a tagged response stream.
module ram_access_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned RD_LAT = 1
) (
   input logic               clock,
   input logic               resetn,
   ram_access_ctrl_if.slave  bus
);

   localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CntOne  = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic [ADDR_W-1:0] ram_address_q, ram_address_d;
   logic [DATA_W-1:0] ram_data_q, ram_data_d;
   logic              ram_wren_q, ram_wren_d;
   logic [ADDR_W:0]   iss_left_q, iss_left_d;   // addresses still to issue
   rsp_tag_t          iss_tag_q, iss_tag_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ADDR_W-1:0] rsp_addr_q, rsp_addr_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_last_q, rsp_last_d;
   rsp_tag_t          tag_out;

   rd_tag_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_tag_pipe (
      .clock  (clock),
      .resetn (resetn),
      .tag_i  (iss_tag_q),
      .tag_o  (tag_out)
   );

   // Next-state for the FSM, RAM port and response stage.
   always_comb begin
      state_d       = state_q;
      req_ready_d   = req_ready_q;
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      ram_wren_d    = 1'b0;
      iss_left_d    = iss_left_q;
      iss_tag_d     = '0;

      // Response register: data/addr hold when no beat is returned.
      rsp_valid_d = tag_out.valid;
      rsp_last_d  = tag_out.valid & tag_out.last;
      rsp_addr_d  = rsp_addr_q;
      rsp_data_d  = rsp_data_q;
      if (tag_out.valid) begin
         rsp_addr_d = tag_out.addr;
         rsp_data_d = bus.ram_q;
      end

      unique case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (bus.req_valid && req_ready_q) begin
               req_ready_d   = 1'b0;
               ram_address_d = bus.req_addr;
               if (bus.req_write) begin
                  ram_data_d = bus.req_wdata;
                  ram_wren_d = 1'b1;
                  state_d    = WRITE;
               end else begin
                  // First address goes out now; req_len more remain.
                  iss_left_d      = {1'b0, bus.req_len};
                  iss_tag_d.valid = 1'b1;
                  iss_tag_d.addr  = bus.req_addr;
                  iss_tag_d.last  = (bus.req_len == '0);
                  state_d         = READ;
               end
            end
         end
         WRITE: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         READ: begin
            if (iss_left_q == '0) begin
               state_d = DRAIN;
            end else begin
               ram_address_d   = ram_address_q + AddrOne;
               iss_left_d      = iss_left_q - CntOne;
               iss_tag_d.valid = 1'b1;
               iss_tag_d.addr  = ram_address_q + AddrOne;
               iss_tag_d.last  = (iss_left_q == CntOne);
            end
         end
         DRAIN: begin
            if (rsp_valid_q && rsp_last_q) begin
               state_d     = IDLE;
               req_ready_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset clears everything including ready.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         req_ready_q   <= 1'b0;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         ram_wren_q    <= 1'b0;
         iss_left_q    <= '0;
         iss_tag_q     <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_addr_q    <= '0;
         rsp_data_q    <= '0;
         rsp_last_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         req_ready_q   <= req_ready_d;
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         ram_wren_q    <= ram_wren_d;
         iss_left_q    <= iss_left_d;
         iss_tag_q     <= iss_tag_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_addr_q    <= rsp_addr_d;
         rsp_data_q    <= rsp_data_d;
         rsp_last_q    <= rsp_last_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.ram_address = ram_address_q;
   assign bus.ram_data    = ram_data_q;
   assign bus.ram_wren    = ram_wren_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_addr    = rsp_addr_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.rsp_last    = rsp_last_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: RAM models, reference memory,
// directed plan steps plus randomized requests.
module tb_ram_access_ctrl;

   localparam int AW   = 5;
   localparam int DW   = 8;
   localparam int LAT  = 1;
   localparam int LAT2 = 2;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } beat_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clock  = 1'b0;
   logic resetn = 1'b0;
   always #5 clock = ~clock;

   ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus  ();
   ram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();

   ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   ram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT2)) u_dut2 (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus2)
   );

   // Behavioural 32x8 RAMs with configurable read latency.
   logic [DW-1:0] mem  [32];
   logic [DW-1:0] qp   [LAT];
   logic [DW-1:0] mem2 [32];
   logic [DW-1:0] qp2  [LAT2];

   always @(posedge clock) begin
      if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
      qp[0] <= mem[bus.ram_address];
      for (int i = 1; i < LAT; i++) qp[i] <= qp[i-1];
   end
   assign bus.ram_q = qp[LAT-1];

   always @(posedge clock) begin
      if (bus2.ram_wren) mem2[bus2.ram_address] <= bus2.ram_data;
      qp2[0] <= mem2[bus2.ram_address];
      for (int i = 1; i < LAT2; i++) qp2[i] <= qp2[i-1];
   end
   assign bus2.ram_q = qp2[LAT2-1];

   // Reference model and scoreboard queues.
   logic [DW-1:0] ref_mem [32];
   beat_t exp_q[$];
   beat_t exp2_q[$];
   wr_t   exp_wr_q[$];
   int    n_cmp      = 0;
   int    n_bad      = 0;
   int    beats_seen = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitors: pop and compare whenever the DUT presents a beat or a RAM write.
   always @(negedge clock) begin
      beat_t e;
      wr_t   w;
      if (resetn) begin
         if (bus.rsp_valid) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               check_eq("rsp_unexpected", 64'(bus.rsp_addr), 64'hFFFF);
            end else begin
               e = exp_q.pop_front();
               check_eq("rsp_beat", {bus.rsp_addr, bus.rsp_data, bus.rsp_last},
                        {e.addr, e.data, e.last});
            end
         end
         if (bus.ram_wren) begin
            if (exp_wr_q.size() == 0) begin
               check_eq("ram_write_unexpected", 64'(bus.ram_address), 64'hFFFF);
            end else begin
               w = exp_wr_q.pop_front();
               check_eq("ram_write", {bus.ram_address, bus.ram_data}, {w.addr, w.data});
            end
         end
         if (bus2.rsp_valid) begin
            if (exp2_q.size() == 0) begin
               check_eq("rsp2_unexpected", 64'(bus2.rsp_addr), 64'hFFFF);
            end else begin
               e = exp2_q.pop_front();
               check_eq("rsp2_beat", {bus2.rsp_addr, bus2.rsp_data, bus2.rsp_last},
                        {e.addr, e.data, e.last});
            end
         end
      end
   end

   // Present a request, wait for acceptance, record the expected outcome.
   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] len,
                        input logic [DW-1:0] d);
      int budget = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_len   = len;
      bus.req_wdata = d;
      while (!bus.req_ready && budget < 200) begin
         @(posedge clock); #1;
         budget++;
      end
      if (!bus.req_ready) begin
         check_eq("accept_timeout", 64'(budget), 64'd0);
      end else begin
         @(posedge clock); #1;
         if (wr) begin
            exp_wr_q.push_back('{addr: a, data: d});
            ref_mem[a] = d;
         end else begin
            for (int i = 0; i <= int'(len); i++) begin
               logic [AW-1:0] ai;
               ai = a + AW'(i);
               exp_q.push_back('{addr: ai, data: ref_mem[ai], last: (i == int'(len))});
            end
         end
      end
      bus.req_valid = 1'b0;
   endtask

   // Called right after a read accept: latency, contiguity, ready afterwards.
   task automatic wait_burst(input int n, input string name);
      int cnt = 0;
      int run = 0;
      while (!bus.rsp_valid && cnt < 20) begin
         @(posedge clock); #1;
         cnt++;
      end
      check_eq({name, "_latency"}, 64'(cnt), 64'(LAT + 1));
      while (bus.rsp_valid && run < 40) begin
         run++;
         @(posedge clock); #1;
      end
      check_eq({name, "_beats"}, 64'(run), 64'(n));
      check_eq({name, "_ready_after"}, 64'(bus.req_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int b0;
      int b1;
      int cnt;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr   = '0;
      bus.req_len    = '0;
      bus.req_wdata  = '0;
      bus2.req_valid = 1'b0;
      bus2.req_write = 1'b0;
      bus2.req_addr  = '0;
      bus2.req_len   = '0;
      bus2.req_wdata = '0;
      for (int i = 0; i < 32; i++) mem2[i] = DW'(8'hC0 + i);

      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      check_eq("reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_addr, bus.rsp_data,
               bus.rsp_last, bus.ram_address, bus.ram_data, bus.ram_wren}, 64'd0);
      resetn = 1'b1;
      #1;
      check_eq("ready_before_edge", 64'(bus.req_ready), 64'd0);
      @(posedge clock); #1;
      check_eq("ready_after_release", 64'(bus.req_ready), 64'd1);

      // 1: write then single-word read.
      issue(1'b1, 5'd3, 5'd0, 8'hA5);
      issue(1'b0, 5'd3, 5'd0, 8'h00);
      wait_burst(1, "t1");

      // 2: preload k+0x10, wrapping read from 30.
      for (int k = 0; k < 32; k++) issue(1'b1, AW'(k), 5'd0, DW'(k + 8'h10));
      issue(1'b0, 5'd30, 5'd3, 8'h00);
      wait_burst(4, "t2");

      // 3: full-memory burst.
      issue(1'b0, 5'd0, 5'd31, 8'h00);
      wait_burst(32, "t3");

      // 4: write held pending during a 4-beat read.
      b0 = beats_seen;
      issue(1'b0, 5'd10, 5'd3, 8'h00);
      issue(1'b1, 5'd5, 5'd0, 8'h77);
      check_eq("t4_write_after_burst", 64'(beats_seen - b0), 64'd4);
      repeat (2) @(posedge clock);
      #1;
      issue(1'b0, 5'd5, 5'd0, 8'h00);
      wait_burst(1, "t4_readback");

      // 5: reset after the second beat of an 8-beat burst.
      b0 = beats_seen;
      issue(1'b0, 5'd12, 5'd7, 8'h00);
      cnt = 0;
      while (beats_seen - b0 < 2 && cnt < 20) begin
         @(negedge clock); #2;
         cnt++;
      end
      check_eq("t5_two_beats", 64'(beats_seen - b0), 64'd2);
      resetn = 1'b0;
      #1;
      check_eq("t5_reset_outputs", {bus.req_ready, bus.rsp_valid, bus.rsp_addr, bus.rsp_data,
               bus.rsp_last, bus.ram_address, bus.ram_data, bus.ram_wren}, 64'd0);
      exp_q.delete();
      repeat (3) @(posedge clock);
      #1;
      check_eq("t5_rsp_in_reset", 64'(bus.rsp_valid), 64'd0);
      resetn = 1'b1;
      b1 = beats_seen;
      #1;
      check_eq("t5_ready_before_edge", 64'(bus.req_ready), 64'd0);
      @(posedge clock); #1;
      check_eq("t5_ready_after_release", 64'(bus.req_ready), 64'd1);
      repeat (10) @(posedge clock);
      #1;
      check_eq("t5_no_beats_after_reset", 64'(beats_seen - b1), 64'd0);

      // Randomized mix of writes and reads.
      for (int n = 0; n < 30; n++) begin
         logic          wr;
         logic [AW-1:0] a;
         logic [AW-1:0] len;
         wr  = 1'($urandom_range(0, 1));
         a   = AW'($urandom_range(0, 31));
         len = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31))
                                           : AW'($urandom_range(0, 5));
         if (wr) begin
            issue(1'b1, a, len, DW'($urandom));
         end else begin
            issue(1'b0, a, len, 8'h00);
            wait_burst(int'(len) + 1, "rand");
         end
      end

      // 6: RD_LAT=2 instance, read addr 7 len 1.
      bus2.req_valid = 1'b1;
      bus2.req_addr  = 5'd7;
      bus2.req_len   = 5'd1;
      cnt = 0;
      while (!bus2.req_ready && cnt < 50) begin
         @(posedge clock); #1;
         cnt++;
      end
      check_eq("t6_ready", 64'(bus2.req_ready), 64'd1);
      @(posedge clock); #1;
      bus2.req_valid = 1'b0;
      exp2_q.push_back('{addr: 5'd7, data: mem2[7], last: 1'b0});
      exp2_q.push_back('{addr: 5'd8, data: mem2[8], last: 1'b1});
      cnt = 0;
      while (!bus2.rsp_valid && cnt < 20) begin
         @(posedge clock); #1;
         cnt++;
      end
      check_eq("t6_latency", 64'(cnt), 64'(LAT2 + 1));
      @(posedge clock); #1;
      check_eq("t6_second_beat", 64'(bus2.rsp_valid), 64'd1);
      @(posedge clock); #1;
      check_eq("t6_after_burst", {bus2.rsp_valid, bus2.req_ready}, 2'b01);

      repeat (4) @(posedge clock);
      #1;
      check_eq("rsp_queue_empty", 64'(exp_q.size()), 64'd0);
      check_eq("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
      check_eq("rsp2_queue_empty", 64'(exp2_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
